fpu_ctx_seq: RTL and testbench

FPU_CTX_SEQ -- requirements
Module: fpu_ctx_seq

---
 rtl/fpu_ctx_seq_if.sv | 23 ++
 rtl/fpu_ctx_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_fpu_ctx_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_ctx_seq_if.sv
// FU configuration bus driven by the context sequencer: crossbar-1 select
// and instruction word at issue time, crossbar-2 select after the FU latency.
interface fpu_ctx_seq_if #(
  parameter int INST_WIDTH      = 64,
  parameter int NUM_OUTPUTS_CB1 = 16,
  parameter int CW1             = 4,
  parameter int NUM_OUTPUTS_CB2 = 4,
  parameter int CW2             = 4
);
  logic [NUM_OUTPUTS_CB1*CW1-1:0] config_cb1_o;
  logic                           cb1_en_o;
  logic [INST_WIDTH-1:0]          config_all_o;
  logic [NUM_OUTPUTS_CB2*CW2-1:0] config_cb2_o;
  logic                           cb2_en_o;

  modport master (
    output config_cb1_o, cb1_en_o, config_all_o, config_cb2_o, cb2_en_o
  );

  modport slave (
    input config_cb1_o, cb1_en_o, config_all_o, config_cb2_o, cb2_en_o
  );
endinterface

// File: rtl/fpu_ctx_seq.sv
// Context sequencer for a crossbar-fed FU: stores NUM_CTX configuration
// contexts, issues each one for rpt+1 cycles, optionally loops, and delays
// the crossbar-2 select and a data bypass to line up with the FU latency.
module fpu_ctx_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int INST_WIDTH      = 64,
  parameter int NUM_INPUTS_CB1  = 14,
  parameter int NUM_OUTPUTS_CB1 = 16,
  parameter int NUM_INPUTS_CB2  = 9,
  parameter int NUM_OUTPUTS_CB2 = 4,
  parameter int NUM_CTX         = 4,
  parameter int FU_LATENCY      = 2,
  parameter int CNT_WIDTH       = 8,
  localparam int CW1 = $clog2(NUM_INPUTS_CB1),
  localparam int CW2 = $clog2(NUM_INPUTS_CB2),
  localparam int AW  = $clog2(NUM_CTX)
) (
  input  logic                           clk,
  input  logic                           rst,
  // context memory write port
  input  logic                           cfg_we,
  input  logic [AW-1:0]                  cfg_addr,
  input  logic [NUM_OUTPUTS_CB1*CW1-1:0] cfg_cb1_i,
  input  logic [NUM_OUTPUTS_CB2*CW2-1:0] cfg_cb2_i,
  input  logic [INST_WIDTH-1:0]          cfg_inst_i,
  input  logic [CNT_WIDTH-1:0]           cfg_rpt_i,
  // run control
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic [AW-1:0]                  last_ctx_i,
  input  logic                           loop_i,
  // FU configuration bus
  fpu_ctx_seq_if.master                  fu,
  // status
  output logic                           busy_o,
  output logic                           done_o,
  output logic [AW-1:0]                  ctx_o,
  output logic                           cfg_err_o,
  // latency-matched data bypass
  input  logic [DATA_WIDTH-1:0]          data_bypass_i,
  input  logic                           data_bypass_valid_i,
  output logic [DATA_WIDTH-1:0]          data_bypass_o,
  output logic                           data_bypass_valid_o
);

  localparam int C1W = NUM_OUTPUTS_CB1 * CW1;
  localparam int C2W = NUM_OUTPUTS_CB2 * CW2;
  localparam int DCW = $clog2(FU_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Context memory
  logic [C1W-1:0]        mem_cb1  [NUM_CTX];
  logic [C2W-1:0]        mem_cb2  [NUM_CTX];
  logic [INST_WIDTH-1:0] mem_inst [NUM_CTX];
  logic [CNT_WIDTH-1:0]  mem_rpt  [NUM_CTX];

  // Sequencer state
  state_t               state;
  logic [AW-1:0]        ctx;
  logic [AW-1:0]        ctx_inc;
  logic [AW-1:0]        last;
  logic                 loop_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [DCW-1:0]       drain_cnt;

  // Registered issue-side outputs
  logic                  cb1_en_q;
  logic [C1W-1:0]        cb1_sel_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic [C2W-1:0]        cb2_sel_q;

  // Delay lines: {enable, cb2 select} and {valid, data}
  logic [C2W:0]        cb2_pipe [FU_LATENCY];
  logic [DATA_WIDTH:0] byp_pipe [FU_LATENCY+1];

  assign ctx_inc = ctx + AW'(1);
  assign ctx_o   = ctx;

  // Out-of-range final-context requests run up to the last stored context.
  function automatic logic [AW-1:0] clamp_last(input logic [AW-1:0] v);
    int unsigned vi;
    vi = v;
    return (vi >= NUM_CTX) ? AW'(NUM_CTX - 1) : v;
  endfunction

  // Context memory writes, accepted only while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the memory is cleared on reset because a run issued straight
      // after reset must present all-zero configurations, not stale ones.
      for (int i = 0; i < NUM_CTX; i++) begin
        mem_cb1[i]  <= '0;
        mem_cb2[i]  <= '0;
        mem_inst[i] <= '0;
        mem_rpt[i]  <= '0;
      end
    end else if (cfg_we && !busy_o) begin
      mem_cb1[cfg_addr]  <= cfg_cb1_i;
      mem_cb2[cfg_addr]  <= cfg_cb2_i;
      mem_inst[cfg_addr] <= cfg_inst_i;
      mem_rpt[cfg_addr]  <= cfg_rpt_i;
    end
  end

  // IDLE/RUN/DRAIN sequencer with registered issue outputs and status.
  always_ff @(posedge clk) begin
    // NOTE: every register here is assigned with <= so all branches see the
    // pre-edge values of state, ctx and cnt; blocking = would leak updates
    // between branches and break the issue timing.
    if (rst) begin
      state     <= IDLE;
      ctx       <= '0;
      cnt       <= '0;
      last      <= '0;
      loop_q    <= 1'b0;
      drain_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      cfg_err_o <= 1'b0;
      cb1_en_q  <= 1'b0;
      cb1_sel_q <= '0;
      inst_q    <= '0;
      cb2_sel_q <= '0;
    end else begin
      done_o <= 1'b0;
      if (cfg_we && busy_o) cfg_err_o <= 1'b1;

      case (state)
        IDLE: begin
          // start uses the pre-edge contents of context 0 if a write lands
          // on the same edge
          if (start_i) begin
            state     <= RUN;
            busy_o    <= 1'b1;
            cfg_err_o <= 1'b0;
            ctx       <= '0;
            cnt       <= mem_rpt[0];
            last      <= clamp_last(last_ctx_i);
            loop_q    <= loop_i;
            cb1_en_q  <= 1'b1;
            cb1_sel_q <= mem_cb1[0];
            inst_q    <= mem_inst[0];
            cb2_sel_q <= mem_cb2[0];
          end
        end

        RUN: begin
          if (stop_i || (cnt == '0 && ctx == last && !loop_q)) begin
            state     <= DRAIN;
            cb1_en_q  <= 1'b0;
            drain_cnt <= DCW'(FU_LATENCY - 1);
            done_o    <= 1'(FU_LATENCY == 1);
          end else if (cnt == '0) begin
            if (ctx < last) begin
              ctx       <= ctx_inc;
              cnt       <= mem_rpt[ctx_inc];
              cb1_sel_q <= mem_cb1[ctx_inc];
              inst_q    <= mem_inst[ctx_inc];
              cb2_sel_q <= mem_cb2[ctx_inc];
            end else begin
              ctx       <= '0;
              cnt       <= mem_rpt[0];
              cb1_sel_q <= mem_cb1[0];
              inst_q    <= mem_inst[0];
              cb2_sel_q <= mem_cb2[0];
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
            done_o    <= (drain_cnt == DCW'(1));
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Crossbar-2 delay line: an issue reappears FU_LATENCY cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FU_LATENCY; i++) cb2_pipe[i] <= '0;
    end else begin
      cb2_pipe[0] <= {cb1_en_q, cb2_sel_q};
      for (int i = 1; i < FU_LATENCY; i++) cb2_pipe[i] <= cb2_pipe[i-1];
    end
  end

  // Data bypass: free-running FU_LATENCY+1 stage pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= FU_LATENCY; i++) byp_pipe[i] <= '0;
    end else begin
      byp_pipe[0] <= {data_bypass_valid_i, data_bypass_i};
      for (int i = 1; i <= FU_LATENCY; i++) byp_pipe[i] <= byp_pipe[i-1];
    end
  end

  assign fu.cb1_en_o     = cb1_en_q;
  assign fu.config_cb1_o = cb1_sel_q;
  assign fu.config_all_o = inst_q;
  assign fu.cb2_en_o     = cb2_pipe[FU_LATENCY-1][C2W];
  assign fu.config_cb2_o = cb2_pipe[FU_LATENCY-1][C2W-1:0];

  assign data_bypass_valid_o = byp_pipe[FU_LATENCY][DATA_WIDTH];
  assign data_bypass_o       = byp_pipe[FU_LATENCY][DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fpu_ctx_seq.sv
// Bench for fpu_ctx_seq: directed and randomized runs checked against an
// issue-sequence model built from the context repeat/last/loop/stop rules.
module tb_fpu_ctx_seq;

  localparam int DATA_WIDTH      = 32;
  localparam int INST_WIDTH      = 64;
  localparam int NUM_INPUTS_CB1  = 14;
  localparam int NUM_OUTPUTS_CB1 = 16;
  localparam int NUM_INPUTS_CB2  = 9;
  localparam int NUM_OUTPUTS_CB2 = 4;
  localparam int NUM_CTX         = 4;
  localparam int FU_LATENCY      = 2;
  localparam int CNT_WIDTH       = 8;
  localparam int CW1 = $clog2(NUM_INPUTS_CB1);
  localparam int CW2 = $clog2(NUM_INPUTS_CB2);
  localparam int AW  = $clog2(NUM_CTX);
  localparam int C1W = NUM_OUTPUTS_CB1 * CW1;
  localparam int C2W = NUM_OUTPUTS_CB2 * CW2;
  localparam int L   = FU_LATENCY;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [C1W-1:0]        cfg_cb1_i;
  logic [C2W-1:0]        cfg_cb2_i;
  logic [INST_WIDTH-1:0] cfg_inst_i;
  logic [CNT_WIDTH-1:0]  cfg_rpt_i;
  logic                  start_i;
  logic                  stop_i;
  logic [AW-1:0]         last_ctx_i;
  logic                  loop_i;
  logic                  busy_o;
  logic                  done_o;
  logic [AW-1:0]         ctx_o;
  logic                  cfg_err_o;
  logic [DATA_WIDTH-1:0] data_bypass_i;
  logic                  data_bypass_valid_i;
  logic [DATA_WIDTH-1:0] data_bypass_o;
  logic                  data_bypass_valid_o;

  fpu_ctx_seq_if #(
    .INST_WIDTH(INST_WIDTH), .NUM_OUTPUTS_CB1(NUM_OUTPUTS_CB1), .CW1(CW1),
    .NUM_OUTPUTS_CB2(NUM_OUTPUTS_CB2), .CW2(CW2)
  ) fu_bus ();

  fpu_ctx_seq #(
    .DATA_WIDTH(DATA_WIDTH), .INST_WIDTH(INST_WIDTH),
    .NUM_INPUTS_CB1(NUM_INPUTS_CB1), .NUM_OUTPUTS_CB1(NUM_OUTPUTS_CB1),
    .NUM_INPUTS_CB2(NUM_INPUTS_CB2), .NUM_OUTPUTS_CB2(NUM_OUTPUTS_CB2),
    .NUM_CTX(NUM_CTX), .FU_LATENCY(FU_LATENCY), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cb1_i(cfg_cb1_i),
    .cfg_cb2_i(cfg_cb2_i), .cfg_inst_i(cfg_inst_i), .cfg_rpt_i(cfg_rpt_i),
    .start_i(start_i), .stop_i(stop_i), .last_ctx_i(last_ctx_i), .loop_i(loop_i),
    .fu(fu_bus),
    .busy_o(busy_o), .done_o(done_o), .ctx_o(ctx_o), .cfg_err_o(cfg_err_o),
    .data_bypass_i(data_bypass_i), .data_bypass_valid_i(data_bypass_valid_i),
    .data_bypass_o(data_bypass_o), .data_bypass_valid_o(data_bypass_valid_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: context contents as the bench believes them stored.
  logic [C1W-1:0]        m_cb1  [NUM_CTX];
  logic [C2W-1:0]        m_cb2  [NUM_CTX];
  logic [INST_WIDTH-1:0] m_inst [NUM_CTX];
  int                    m_rpt  [NUM_CTX];
  logic                  err_exp;
  // Bypass reference: the last three {valid,data} values presented.
  logic [DATA_WIDTH:0]   by_hist [3];
  bit                    by_armed  = 1'b0;
  bit                    bp_manual = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: present bypass stimulus, advance, check the bypass output.
  task automatic tick();
    if (!bp_manual) begin
      data_bypass_i       = $urandom();
      data_bypass_valid_i = 1'($urandom_range(0, 1));
    end
    by_hist[0] = by_hist[1];
    by_hist[1] = by_hist[2];
    by_hist[2] = {data_bypass_valid_i, data_bypass_i};
    if (rst) begin
      for (int i = 0; i < 3; i++) by_hist[i] = '0;
      by_armed = 1'b1;
    end
    @(posedge clk);
    #1;
    if (by_armed) begin
      check("bypass_data", 64'(data_bypass_o), 64'(by_hist[0][DATA_WIDTH-1:0]));
      check("bypass_valid", 64'(data_bypass_valid_o), 64'(by_hist[0][DATA_WIDTH]));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_CTX; i++) begin
      m_cb1[i] = '0; m_cb2[i] = '0; m_inst[i] = '0; m_rpt[i] = 0;
    end
    err_exp = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cb1_en"}, 64'(fu_bus.cb1_en_o), 64'd0);
    check({tag, "_cb2_en"}, 64'(fu_bus.cb2_en_o), 64'd0);
    check({tag, "_cfg_cb1"}, 64'(fu_bus.config_cb1_o), 64'd0);
    check({tag, "_cfg_all"}, 64'(fu_bus.config_all_o), 64'd0);
    check({tag, "_cfg_cb2"}, 64'(fu_bus.config_cb2_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_ctx"}, 64'(ctx_o), 64'd0);
    check({tag, "_cfg_err"}, 64'(cfg_err_o), 64'd0);
  endtask

  task automatic write_ctx(input int a, input int rpt);
    cfg_we     = 1'b1;
    cfg_addr   = AW'(a);
    cfg_cb1_i  = C1W'({$urandom(), $urandom()});
    cfg_cb2_i  = C2W'($urandom());
    cfg_inst_i = INST_WIDTH'({$urandom(), $urandom()});
    cfg_rpt_i  = CNT_WIDTH'(rpt);
    m_cb1[a] = cfg_cb1_i; m_cb2[a] = cfg_cb2_i; m_inst[a] = cfg_inst_i; m_rpt[a] = rpt;
    tick();
    cfg_we = 1'b0;
  endtask

  // Start a run and check every cycle until the sequencer is idle again.
  // stop_at/start_at/wr_at/rst_at: run cycle (1 = first issue cycle) during
  // which that input is held high; 0 means never.
  task automatic run_seq(input int lastv, input bit loopv, input int stop_at,
                         input bit stop_with_start, input int start_at,
                         input int wr_at, input int rst_at);
    int  seq[$];
    int  c, n, lastc, wr_a, st, wr, rs, idx;
    bit  done_build;
    lastc = (lastv >= NUM_CTX) ? NUM_CTX - 1 : lastv;
    c = 0;
    done_build = 1'b0;
    while (!done_build && seq.size() < 64) begin
      for (int r = 0; r <= m_rpt[c]; r++) begin
        seq.push_back(c);
        if (stop_at != 0 && seq.size() == stop_at) break;
      end
      if (stop_at != 0 && seq.size() >= stop_at) done_build = 1'b1;
      else if (c < lastc) c++;
      else if (loopv) c = 0;
      else done_build = 1'b1;
    end
    n  = seq.size();
    st = (start_at <= n + L) ? start_at : 0;
    wr = (wr_at <= n + L) ? wr_at : 0;
    rs = (rst_at <= n) ? rst_at : 0;
    wr_a = 0;

    start_i    = 1'b1;
    stop_i     = stop_with_start;
    last_ctx_i = AW'(lastv);
    loop_i     = loopv;
    tick();
    err_exp = 1'b0;

    for (int k = 1; k <= n + L + 1; k++) begin
      if (rs != 0 && k == rs + 1) begin
        check_all_zero("rst_abort");
        clear_model();
        rst = 1'b0;
        stop_i = 1'b0; start_i = 1'b0; cfg_we = 1'b0;
        for (int j = 0; j < 4; j++) begin
          tick();
          check("rst_no_done", 64'(done_o), 64'd0);
          check("rst_idle_busy", 64'(busy_o), 64'd0);
        end
        return;
      end
      if (wr != 0 && k == wr + 1) err_exp = 1'b1;

      idx = (k <= n) ? k - 1 : n - 1;
      check("cb1_en", 64'(fu_bus.cb1_en_o), 64'(k <= n));
      check("ctx", 64'(ctx_o), 64'(seq[idx]));
      check("cfg_cb1", 64'(fu_bus.config_cb1_o), 64'(m_cb1[seq[idx]]));
      check("cfg_all", 64'(fu_bus.config_all_o), 64'(m_inst[seq[idx]]));
      check("cb2_en", 64'(fu_bus.cb2_en_o), 64'(k > L && k <= n + L));
      if (k > L && k <= n + L)
        check("cfg_cb2", 64'(fu_bus.config_cb2_o), 64'(m_cb2[seq[k-L-1]]));
      check("busy", 64'(busy_o), 64'(k <= n + L));
      check("done", 64'(done_o), 64'(k == n + L));
      check("cfg_err", 64'(cfg_err_o), 64'(err_exp));

      stop_i  = (k == stop_at);
      start_i = (st != 0 && k == st);
      rst     = (rs != 0 && k == rs);
      cfg_we  = (wr != 0 && k == wr);
      if (cfg_we) begin
        wr_a       = $urandom_range(0, NUM_CTX - 1);
        cfg_addr   = AW'(wr_a);
        cfg_cb1_i  = ~m_cb1[wr_a];
        cfg_cb2_i  = ~m_cb2[wr_a];
        cfg_inst_i = ~m_inst[wr_a];
        cfg_rpt_i  = CNT_WIDTH'(m_rpt[wr_a] + 1);
      end
      tick();
    end
    stop_i = 1'b0; start_i = 1'b0; cfg_we = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int  lv, sa, sta, wra;
  bit  lp;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_cb1_i = '0; cfg_cb2_i = '0;
    cfg_inst_i = '0; cfg_rpt_i = '0; start_i = 1'b0; stop_i = 1'b0;
    last_ctx_i = '0; loop_i = 1'b0; data_bypass_i = '0; data_bypass_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) by_hist[i] = '0;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");
    tick();

    // Basic run: ctx0 x3, ctx1 x1, then drain.
    write_ctx(0, 2);
    write_ctx(1, 0);
    write_ctx(2, 1);
    write_ctx(3, 0);
    run_seq(1, 1'b0, 0, 1'b0, 0, 0, 0);
    tick();

    // Looping run stopped on its sixth issue cycle.
    run_seq(1, 1'b1, 6, 1'b0, 0, 0, 0);
    tick();

    // Write during a run is dropped and flagged; the next start clears the flag.
    run_seq(1, 1'b0, 0, 1'b0, 0, 2, 0);
    check("err_sticky_idle", 64'(cfg_err_o), 64'd1);
    tick();
    check("err_sticky_idle2", 64'(cfg_err_o), 64'd1);
    run_seq(3, 1'b0, 0, 1'b0, 0, 0, 0);
    tick();

    // start+stop together in IDLE, plus a second start mid-run.
    run_seq(3, 1'b0, 0, 1'b1, 3, 0, 0);
    tick();

    // Randomized contexts and run controls.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < NUM_CTX; a++) write_ctx(a, $urandom_range(0, 3));
      lv  = $urandom_range(0, NUM_CTX - 1);
      lp  = 1'($urandom_range(0, 1));
      sa  = $urandom_range(0, 12);
      if (lp && sa == 0) sa = 7;
      sta = $urandom_range(0, 8);
      wra = $urandom_range(0, 8);
      run_seq(lv, lp, sa, 1'($urandom_range(0, 1)), sta, wra, 0);
      tick();
    end

    // Reset during the third run cycle aborts silently and clears memory.
    write_ctx(0, 3);
    write_ctx(1, 1);
    run_seq(3, 1'b0, 0, 1'b0, 0, 0, 3);
    run_seq(3, 1'b0, 0, 1'b0, 0, 0, 0);
    tick();

    // Directed bypass pulse: appears exactly three cycles after it is driven.
    bp_manual = 1'b1;
    data_bypass_i = 32'hDEADBEEF; data_bypass_valid_i = 1'b1;
    tick();
    data_bypass_i = '0; data_bypass_valid_i = 1'b0;
    tick();
    tick();
    check("bypass_pulse_data", 64'(data_bypass_o), 64'hDEADBEEF);
    check("bypass_pulse_valid", 64'(data_bypass_valid_o), 64'd1);
    tick();
    check("bypass_pulse_gone", 64'(data_bypass_valid_o), 64'd0);
    bp_manual = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
